cpu_hazard_unit: RTL and testbench
==================================

CPU_HAZARD_UNIT -- requirements
Module: cpu_hazard_unit

Interface
REQ-001 Parameter NUM_REGS, default 16, architectural register count; REG_W = $clog2(NUM_REGS).
REQ-002 Parameter PIPE_DEPTH, default 4, in-flight stages tracked after issue (dec, exec, mem, wb); legal range 1..8.
REQ-003 Parameter FWD_EN, default 0; 0 = no forwarding, 1 = full bypass network downstream.
REQ-004 Parameter JB_PENALTY, default 2, jump/branch stall cycles; legal range 1..15.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 if_valid  input  1  fetched instruction present at issue point.
REQ-008 if_rs1 / if_rs2  input  REG_W each  source register indices.
REQ-009 if_rs1_used / if_rs2_used  input  1 each  source actually read (L-type: rs1 only; R-type: both).
REQ-010 if_wrt_en  input  1  instruction writes a register.
REQ-011 if_wrt_reg  input  REG_W  destination register.
REQ-012 if_is_load  input  1  destination written from memory.
REQ-013 if_is_jb  input  1  instruction is a jump/branch.
REQ-014 jb_resolve  input  1  branch resolved early; cancels remaining jb penalty.
REQ-015 rw_stall  output  1  read-after-write hazard; hold IF.
REQ-016 jb_stall  output  1  control hazard; hold IF.
REQ-017 issue_fire  output  1  if_valid & !rw_stall & !jb_stall.
REQ-018 stall_cycles  output  32  saturating count of cycles with if_valid and (rw_stall | jb_stall).

Function
REQ-019 Scoreboard: PIPE_DEPTH-entry shift register, each entry {valid, wrt_en, wrt_reg, is_load}; entry 0 = youngest (dec).
REQ-020 Every cycle all entries shift one stage and the oldest is discarded; entry 0 loads the issued instruction's fields when issue_fire, else a bubble (valid=0).
REQ-021 A match is a valid entry with wrt_en=1 whose wrt_reg equals a used source (if_rs1 with if_rs1_used, or if_rs2 with if_rs2_used).
REQ-022 FWD_EN=0: rw_stall = if_valid & match in any entry 0..PIPE_DEPTH-1.
REQ-023 FWD_EN=1: rw_stall = if_valid & match in entry 0 with is_load=1 only (load-use, one-cycle bubble).
REQ-024 rw_stall and jb_stall are combinational from current state and inputs; both 0 when if_valid=0.
REQ-025 4-bit jb counter: loads JB_PENALTY on issue_fire with if_is_jb=1; otherwise decrements when nonzero; jb_stall = (counter != 0).
REQ-026 jb_resolve clears counter to 0 next cycle; if jb_resolve coincides with a jb issue, the load wins.
REQ-027 jb_stall and rw_stall are independent; both may assert together, and issue is blocked while either is high.
REQ-028 stall_cycles increments by 1 per qualifying cycle and holds at 32'hFFFF_FFFF.
REQ-029 A write to register 0 is tracked like any other register; no hardwired-zero exemption.

Reset
REQ-030 rst=1 clears all scoreboard valid bits, jb counter and stall_cycles to 0 on the next edge, including mid-stall or mid-penalty.
REQ-031 After reset, rw_stall=0, jb_stall=0 and issue_fire=if_valid.

Structure
REQ-032 Shared package cpu_pkg holds the scoreboard entry struct typedef, the default NUM_REGS/PIPE_DEPTH/JB_PENALTY constants and the opcode-class localparams used by the upstream decoder.
REQ-033 One sub-module, cpu_sb_stage (single scoreboard entry register plus source comparator), instantiated PIPE_DEPTH times by a generate loop.
REQ-034 Opcode-to-class decode (L/R/jb) stays outside this block.

Verification
REQ-035 FWD_EN=0, depth 4: issue wrt r3, then reader rs1=r3 -> rw_stall high exactly 4 cycles, issue_fire on 5th, stall_cycles=4.
REQ-036 FWD_EN=1: issue load wrt r5, then R-type rs2=r5 -> 1 stall cycle; non-load wrt r5 followed by reader -> 0 stall cycles.
REQ-037 JB_PENALTY=2: issue jb -> jb_stall 2 cycles; repeat with jb_resolve in the cycle after issue -> jb_stall 1 cycle.
REQ-038 Reader with if_rs2_used=0 and rs2 matching an in-flight write -> no stall; with if_rs2_used=1 -> stall.
REQ-039 rst asserted during the 2nd cycle of a 4-cycle rw stall -> rw_stall=0 and stall_cycles=0 after the edge; the same reader then issues immediately.
REQ-040 Force stall_cycles to 32'hFFFF_FFFE, then stall 3 cycles -> holds at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU issue/hazard logic.
//   - default architectural sizes used by the hazard unit
//   - scoreboard entry record carried through the in-flight pipeline
//   - opcode-class encodings produced by the upstream decoder
package cpu_pkg;

    localparam int DEF_NUM_REGS   = 16;
    localparam int DEF_PIPE_DEPTH = 4;
    localparam int DEF_JB_PENALTY = 2;

    // Scoreboard register field is sized for up to 256 architectural
    // registers; narrower indices are zero-extended before comparison.
    localparam int SB_REG_W = 8;
    localparam int JB_CNT_W = 4;

    typedef struct packed {
        logic                valid;
        logic                wrt_en;
        logic [SB_REG_W-1:0] wrt_reg;
        logic                is_load;
    } sb_entry_t;

    typedef enum logic [1:0] {
        OP_CLASS_NONE = 2'd0,
        OP_CLASS_L    = 2'd1,
        OP_CLASS_R    = 2'd2,
        OP_CLASS_JB   = 2'd3
    } op_class_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

endpackage

// File: rtl/cpu_sb_stage.sv
// One scoreboard slot: registers an in-flight instruction's write info and
// compares it against the source registers at the issue point.
//   clk, rst        : clock, synchronous active-high reset
//   entry_i         : record shifting in from the younger slot (or issue)
//   rs1_i/rs2_i     : zero-extended source indices at the issue point
//   rs1_used_i/...  : source actually read
//   entry_o         : registered record held by this slot
//   match_o         : this slot writes a register the issuing instr reads
module cpu_sb_stage
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  sb_entry_t           entry_i,
    input  logic [SB_REG_W-1:0] rs1_i,
    input  logic                rs1_used_i,
    input  logic [SB_REG_W-1:0] rs2_i,
    input  logic                rs2_used_i,
    output sb_entry_t           entry_o,
    output logic                match_o
);

    sb_entry_t entry_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_i;
        end
    end

    always_comb begin
        match_o = entry_q.valid & entry_q.wrt_en &
                  ((rs1_used_i & (rs1_i == entry_q.wrt_reg)) |
                   (rs2_used_i & (rs2_i == entry_q.wrt_reg)));
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/cpu_hazard_unit.sv
// Issue-point hazard detection: read-after-write interlock via a shifting
// scoreboard of in-flight writers, plus a fixed jump/branch penalty timer.
//   clk, rst                  : clock, synchronous active-high reset
//   if_valid                  : instruction present at issue point
//   if_rs1/if_rs2, *_used     : source registers and whether they are read
//   if_wrt_en/if_wrt_reg      : destination write
//   if_is_load, if_is_jb      : load / control-transfer instruction
//   jb_resolve                : early branch resolution, cancels penalty
//   rw_stall, jb_stall        : hold fetch
//   issue_fire                : instruction leaves the issue point this cycle
//   stall_cycles              : saturating count of stalled valid cycles
module cpu_hazard_unit
    import cpu_pkg::*;
#(
    parameter  int NUM_REGS   = DEF_NUM_REGS,
    parameter  int PIPE_DEPTH = DEF_PIPE_DEPTH,
    parameter  int FWD_EN     = 0,
    parameter  int JB_PENALTY = DEF_JB_PENALTY,
    localparam int REG_W      = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [REG_W-1:0] if_rs1,
    input  logic [REG_W-1:0] if_rs2,
    input  logic             if_rs1_used,
    input  logic             if_rs2_used,
    input  logic             if_wrt_en,
    input  logic [REG_W-1:0] if_wrt_reg,
    input  logic             if_is_load,
    input  logic             if_is_jb,
    input  logic             jb_resolve,
    output logic             rw_stall,
    output logic             jb_stall,
    output logic             issue_fire,
    output logic [31:0]      stall_cycles
);

    logic [SB_REG_W-1:0] rs1_ext;
    logic [SB_REG_W-1:0] rs2_ext;
    sb_entry_t           issue_entry;
    sb_entry_t           stage_q [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] match;
    logic                rw_hit;

    logic [JB_CNT_W-1:0] jb_cnt_q, jb_cnt_d;
    logic [31:0]         stall_cnt_q, stall_cnt_d;

    assign rs1_ext = SB_REG_W'(if_rs1);
    assign rs2_ext = SB_REG_W'(if_rs2);

    // Stalled cycles push a bubble so the scoreboard keeps draining.
    always_comb begin
        issue_entry = '0;
        if (issue_fire) begin
            issue_entry.valid   = 1'b1;
            issue_entry.wrt_en  = if_wrt_en;
            issue_entry.wrt_reg = SB_REG_W'(if_wrt_reg);
            issue_entry.is_load = if_is_load;
        end
    end

    for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_sb
        sb_entry_t stage_in;
        if (g == 0) begin : g_head
            assign stage_in = issue_entry;
        end else begin : g_tail
            assign stage_in = stage_q[g-1];
        end

        cpu_sb_stage u_stage (
            .clk        (clk),
            .rst        (rst),
            .entry_i    (stage_in),
            .rs1_i      (rs1_ext),
            .rs1_used_i (if_rs1_used),
            .rs2_i      (rs2_ext),
            .rs2_used_i (if_rs2_used),
            .entry_o    (stage_q[g]),
            .match_o    (match[g])
        );
    end

    // With full bypass only a load in the youngest slot cannot be forwarded.
    always_comb begin
        if (FWD_EN != 0) begin
            rw_hit = match[0] & stage_q[0].is_load;
        end else begin
            rw_hit = |match;
        end
    end

    assign rw_stall   = if_valid & rw_hit;
    assign jb_stall   = if_valid & (jb_cnt_q != '0);
    assign issue_fire = if_valid & ~rw_stall & ~jb_stall;

    always_comb begin
        jb_cnt_d = jb_cnt_q;
        if (issue_fire && if_is_jb) begin
            jb_cnt_d = JB_CNT_W'(JB_PENALTY);
        end else if (jb_resolve) begin
            jb_cnt_d = '0;
        end else if (jb_cnt_q != '0) begin
            jb_cnt_d = jb_cnt_q - 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((rw_stall || jb_stall) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            jb_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            jb_cnt_q    <= jb_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_cpu_hazard_unit.sv
module tb_cpu_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       if_valid;
    logic [3:0] if_rs1, if_rs2;
    logic       if_rs1_used, if_rs2_used;
    logic       if_wrt_en;
    logic [3:0] if_wrt_reg;
    logic       if_is_load, if_is_jb, jb_resolve;

    logic        rw0, jb0, fire0;
    logic [31:0] cnt0;
    logic        rw1, jb1, fire1;
    logic [31:0] cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_hazard_unit #(.NUM_REGS(16), .PIPE_DEPTH(4), .FWD_EN(0), .JB_PENALTY(2)) dut0 (
        .clk(clk), .rst(rst), .if_valid(if_valid),
        .if_rs1(if_rs1), .if_rs2(if_rs2),
        .if_rs1_used(if_rs1_used), .if_rs2_used(if_rs2_used),
        .if_wrt_en(if_wrt_en), .if_wrt_reg(if_wrt_reg),
        .if_is_load(if_is_load), .if_is_jb(if_is_jb), .jb_resolve(jb_resolve),
        .rw_stall(rw0), .jb_stall(jb0), .issue_fire(fire0), .stall_cycles(cnt0)
    );

    cpu_hazard_unit #(.NUM_REGS(16), .PIPE_DEPTH(4), .FWD_EN(1), .JB_PENALTY(2)) dut1 (
        .clk(clk), .rst(rst), .if_valid(if_valid),
        .if_rs1(if_rs1), .if_rs2(if_rs2),
        .if_rs1_used(if_rs1_used), .if_rs2_used(if_rs2_used),
        .if_wrt_en(if_wrt_en), .if_wrt_reg(if_wrt_reg),
        .if_is_load(if_is_load), .if_is_jb(if_is_jb), .jb_resolve(jb_resolve),
        .rw_stall(rw1), .jb_stall(jb1), .issue_fire(fire1), .stall_cycles(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then changed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_valid = 0; if_rs1 = 0; if_rs2 = 0; if_rs1_used = 0; if_rs2_used = 0;
        if_wrt_en = 0; if_wrt_reg = 0; if_is_load = 0; if_is_jb = 0; jb_resolve = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic writer(input logic [3:0] rd, input logic ld);
        idle();
        if_valid = 1; if_wrt_en = 1; if_wrt_reg = rd; if_is_load = ld;
    endtask

    task automatic reader(input logic [3:0] r1, input logic u1, input logic [3:0] r2, input logic u2);
        idle();
        if_valid = 1; if_rs1 = r1; if_rs1_used = u1; if_rs2 = r2; if_rs2_used = u2;
    endtask

    initial begin
        idle();
        rst = 1;
        step(); step();
        rst = 0;

        // Reset state
        #1;
        chk("rst_rw", {31'd0, rw0}, 0);
        chk("rst_jb", {31'd0, jb0}, 0);
        chk("rst_fire_novalid", {31'd0, fire0}, 0);
        chk("rst_cnt", cnt0, 0);
        if_valid = 1;
        #1;
        chk("rst_fire_valid", {31'd0, fire0}, 1);
        step();

        // RAW without forwarding: 4 stall cycles; forwarding of non-load: none
        do_reset();
        writer(4'd3, 1'b0);
        #1;
        chk("w3_fire", {31'd0, fire0}, 1);
        step();
        reader(4'd3, 1'b1, 4'd0, 1'b0);
        #1;
        chk("fwd_nonload_rw", {31'd0, rw1}, 0);
        chk("fwd_nonload_fire", {31'd0, fire1}, 1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("raw_stall_c%0d", k), {31'd0, rw0}, 1);
            chk($sformatf("raw_nofire_c%0d", k), {31'd0, fire0}, 0);
            step();
        end
        chk("raw_release_rw", {31'd0, rw0}, 0);
        chk("raw_release_fire", {31'd0, fire0}, 1);
        chk("raw_cnt4", cnt0, 4);
        chk("fwd_nonload_cnt", cnt1, 0);
        step();

        // Load-use with forwarding: exactly one bubble
        do_reset();
        writer(4'd5, 1'b1);
        step();
        reader(4'd1, 1'b1, 4'd5, 1'b1);
        #1;
        chk("ldu_stall", {31'd0, rw1}, 1);
        chk("ldu_nofire", {31'd0, fire1}, 0);
        step();
        chk("ldu_release", {31'd0, rw1}, 0);
        chk("ldu_fire", {31'd0, fire1}, 1);
        chk("ldu_cnt1", cnt1, 1);
        chk("ldu_nofwd_still", {31'd0, rw0}, 1);
        step();

        // Unused rs2 must not stall; used rs2 must
        do_reset();
        writer(4'd7, 1'b0);
        step();
        reader(4'd2, 1'b1, 4'd7, 1'b0);
        #1;
        chk("rs2_unused_rw", {31'd0, rw0}, 0);
        chk("rs2_unused_fire", {31'd0, fire0}, 1);
        step();
        reader(4'd2, 1'b1, 4'd7, 1'b1);
        #1;
        chk("rs2_used_rw", {31'd0, rw0}, 1);
        step();

        // Register 0 is tracked like any other
        do_reset();
        writer(4'd0, 1'b0);
        step();
        reader(4'd0, 1'b1, 4'd0, 1'b0);
        #1;
        chk("r0_rw", {31'd0, rw0}, 1);
        step();

        // Jump/branch penalty: 2 cycles, with a gap where if_valid is low
        do_reset();
        idle(); if_valid = 1; if_is_jb = 1;
        #1;
        chk("jb_issue_fire", {31'd0, fire0}, 1);
        step();
        idle();
        #1;
        chk("jb_novalid_stall", {31'd0, jb0}, 0);
        step();
        if_valid = 1;
        #1;
        chk("jb_c2_stall", {31'd0, jb0}, 1);
        step();
        chk("jb_c3_stall", {31'd0, jb0}, 0);
        chk("jb_c3_fire", {31'd0, fire0}, 1);

        do_reset();
        idle(); if_valid = 1; if_is_jb = 1;
        step();
        idle(); if_valid = 1;
        #1;
        chk("jb2_c1", {31'd0, jb0}, 1);
        step();
        chk("jb2_c2", {31'd0, jb0}, 1);
        step();
        chk("jb2_c3", {31'd0, jb0}, 0);
        chk("jb2_cnt", cnt0, 2);

        // Early resolve cuts penalty to one cycle
        do_reset();
        idle(); if_valid = 1; if_is_jb = 1;
        step();
        idle(); if_valid = 1; jb_resolve = 1;
        #1;
        chk("jbres_c1", {31'd0, jb0}, 1);
        step();
        jb_resolve = 0;
        #1;
        chk("jbres_c2", {31'd0, jb0}, 0);
        chk("jbres_fire", {31'd0, fire0}, 1);

        // Resolve coinciding with a jb issue: the load wins
        do_reset();
        idle(); if_valid = 1; if_is_jb = 1; jb_resolve = 1;
        step();
        idle(); if_valid = 1;
        #1;
        chk("jbres_coincide", {31'd0, jb0}, 1);
        step();

        // Both stalls together
        do_reset();
        writer(4'd9, 1'b0); if_is_jb = 1;
        step();
        reader(4'd9, 1'b1, 4'd0, 1'b0);
        #1;
        chk("both_rw", {31'd0, rw0}, 1);
        chk("both_jb", {31'd0, jb0}, 1);
        chk("both_nofire", {31'd0, fire0}, 0);
        step();

        // Reset during the 2nd cycle of a RAW stall
        do_reset();
        writer(4'd3, 1'b0);
        step();
        reader(4'd3, 1'b1, 4'd0, 1'b0);
        step();
        chk("midrst_stall", {31'd0, rw0}, 1);
        chk("midrst_cnt1", cnt0, 1);
        rst = 1;
        step();
        rst = 0;
        #1;
        chk("midrst_rw", {31'd0, rw0}, 0);
        chk("midrst_cnt0", cnt0, 0);
        chk("midrst_fire", {31'd0, fire0}, 1);
        step();

        // Saturation of the stall counter
        do_reset();
        writer(4'd3, 1'b0);
        step();
        force dut0.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut0.stall_cnt_q;
        reader(4'd3, 1'b1, 4'd0, 1'b0);
        #1;
        chk("sat_preload", cnt0, 32'hFFFF_FFFE);
        step();
        chk("sat_c1", cnt0, 32'hFFFF_FFFF);
        step();
        step();
        chk("sat_hold", cnt0, 32'hFFFF_FFFF);

        idle();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
